// File: rtl/pc_gen.sv
// Program-counter generation stage: boots, advances by 4, takes redirects,
// buffers a redirect across a stall, traps on misaligned targets and halts.
module pc_gen #(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = 32'h8000_0000,
  parameter logic [WIDTH-1:0] TRAP_VEC = 32'h8000_0100,
  parameter int unsigned      CNT_W    = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_i,
  input  logic             redirect_valid_i,
  input  logic [WIDTH-1:0] redirect_target_i,
  input  logic             halt_i,
  output logic [WIDTH-1:0] pc_o,
  output logic [WIDTH-1:0] next_pc_o,
  output logic             pc_valid_o,
  output logic             misalign_o,
  output logic [WIDTH-1:0] badaddr_o,
  output logic             halted_o,
  output logic [CNT_W-1:0] adv_cnt_o
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pend_target_q;
  logic             pend_valid_q;
  logic             pc_valid_q;
  logic             misalign_q;
  logic [WIDTH-1:0] badaddr_q;
  logic             halted_q;
  logic [CNT_W-1:0] cnt_q;

  logic [WIDTH-1:0] cand_d;
  logic [WIDTH-1:0] next_pc_d;
  logic             trap_d;

  function automatic logic is_misaligned(input logic [WIDTH-1:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

  // Next-PC decision; only an advancing RUN cycle moves the PC.
  always_comb begin
    cand_d    = pc_q + {{(WIDTH-3){1'b0}}, 3'b100};
    trap_d    = 1'b0;
    next_pc_d = pc_q;
    if ((state_q == ST_RUN) && !halt_i && !stall_i) begin
      if (redirect_valid_i) begin
        cand_d = redirect_target_i;
        trap_d = is_misaligned(redirect_target_i);
      end else if (pend_valid_q) begin
        cand_d = pend_target_q;
        trap_d = is_misaligned(pend_target_q);
      end else begin
        trap_d = 1'b0;
      end
      next_pc_d = trap_d ? TRAP_VEC : cand_d;
    end else begin
      next_pc_d = pc_q;
    end
  end

  // State machine and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_BOOT;
      pc_q          <= RESET_PC;
      pend_valid_q  <= 1'b0;
      pend_target_q <= '0;
      pc_valid_q    <= 1'b0;
      misalign_q    <= 1'b0;
      badaddr_q     <= '0;
      halted_q      <= 1'b0;
      cnt_q         <= '0;
    end else begin
      misalign_q <= 1'b0;
      case (state_q)
        ST_BOOT: begin
          state_q    <= ST_RUN;
          pc_valid_q <= 1'b1;
        end
        ST_RUN: begin
          if (halt_i) begin
            state_q      <= ST_HALT;
            halted_q     <= 1'b1;
            pc_valid_q   <= 1'b0;
            pend_valid_q <= 1'b0;
          end else if (stall_i) begin
            if (redirect_valid_i) begin
              pend_valid_q  <= 1'b1;
              pend_target_q <= redirect_target_i;
            end
          end else begin
            pc_q         <= next_pc_d;
            pend_valid_q <= 1'b0;
            cnt_q        <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            misalign_q   <= trap_d;
            if (trap_d) begin
              badaddr_q <= cand_d;
            end
          end
        end
        ST_HALT: begin
          halted_q   <= 1'b1;
          pc_valid_q <= 1'b0;
        end
        default: begin
          state_q    <= ST_BOOT;
          pc_q       <= RESET_PC;
          pc_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign pc_o       = pc_q;
  assign next_pc_o  = next_pc_d;
  assign pc_valid_o = pc_valid_q;
  assign misalign_o = misalign_q;
  assign badaddr_o  = badaddr_q;
  assign halted_o   = halted_q;
  assign adv_cnt_o  = cnt_q;

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Program-counter generation stage, directly upstream of fetch.
- Holds the architectural PC and drives the fetch address (pc_o feeds fetch pc_i) each cycle.
- Advances the PC sequentially by 4, or takes a redirect (branch/jump) target.
- Supports stall with a held redirect, misaligned-target trapping, and a terminal halt on ebreak.

Parameters:
- WIDTH, 32: PC/address width.
- RESET_PC, 32'h8000_0000: PC value after reset.
- TRAP_VEC, 32'h8000_0100: PC taken on a misaligned redirect target.
- CNT_W, 64: width of the PC-advance counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- stall_i  input  1  hold the PC this cycle.
- redirect_valid_i  input  1  redirect request this cycle.
- redirect_target_i  input  WIDTH  redirect target address.
- halt_i  input  1  ebreak seen by fetch/decode; stop the core.
- pc_o  output  WIDTH  current PC; drives fetch pc_i.
- next_pc_o  output  WIDTH  combinational value pc_o takes at the next edge.
- pc_valid_o  output  1  pc_o is a live fetch address.
- misalign_o  output  1  one-cycle pulse: pc_o is TRAP_VEC because of a misaligned target.
- badaddr_o  output  WIDTH  last misaligned target, held until the next trap or reset.
- halted_o  output  1  core halted.
- adv_cnt_o  output  CNT_W  number of PC updates since reset.

Behaviour:
- Reset (rst=1 at an edge):
  - pc_o=RESET_PC, state=BOOT, pend_valid=0, pend_target=0.
  - misalign_o=0, badaddr_o=0, halted_o=0, pc_valid_o=0, adv_cnt_o=0.
  - Reset wins over every other input, including mid-stall, mid-pending and HALT.
- States: BOOT, RUN, HALT. pc_valid_o=1 only in RUN.
- BOOT: lasts exactly one cycle; PC is held; all inputs are ignored; next state is RUN with pc_o=RESET_PC.
- RUN, evaluated per edge in priority order:
  1. halt_i=1: go to HALT; PC held; pending redirect discarded; no counter increment.
  2. stall_i=1: PC held. If redirect_valid_i=1, latch pend_target=redirect_target_i and set pend_valid=1; a newer redirect overwrites an older one. No counter increment.
  3. Otherwise the next-PC candidate is:
     - redirect_target_i if redirect_valid_i=1 (a current redirect beats a pending one);
     - else pend_target if pend_valid=1;
     - else pc_o+4.
     The PC updates, pend_valid clears, and adv_cnt_o increments by 1.
- Misaligned candidate (redirect or pending with bits[1:0]!=0):
  - pc_o<=TRAP_VEC, badaddr_o<=candidate, misalign_o=1 for exactly the cycle pc_o first equals TRAP_VEC.
  - The counter still increments.
  - pc+4 never misaligns (PC is always 4-aligned).
- Wrap-around: pc_o+4 wraps modulo 2^WIDTH (32'hFFFF_FFFC -> 32'h0000_0000). adv_cnt_o wraps modulo 2^CNT_W.
- HALT: terminal until rst.
  - halted_o=1 (registered, asserted the cycle after halt_i is sampled); pc_valid_o=0.
  - pc_o and adv_cnt_o frozen; all other inputs ignored.
- next_pc_o: combinational mirror of the RUN decision logic. Equals pc_o in BOOT, HALT, during stall, and when halt_i=1. Equals TRAP_VEC for a misaligned candidate.
- All outputs except next_pc_o are registered; redirect-to-pc_o latency is 1 cycle.
- halt_i and stall_i asserted together: halt wins. A redirect arriving with halt_i is dropped.

Test Plan:
- Reset then run: rst high 2 cycles then low, no stimulus.
  -> pc_o=0x8000_0000 with pc_valid_o=0 for 1 cycle, then pc_valid_o=1.
  -> pc_o follows 0x8000_0000, 0x8000_0004, 0x8000_0008; adv_cnt_o=2 after the third.
- Redirect: redirect_valid_i=1, target 0x8000_0040 while pc_o=0x8000_0008, no stall.
  -> next_pc_o=0x8000_0040 in the same cycle; pc_o=0x8000_0040 next cycle; then 0x8000_0044.
- Stall with pending redirects: stall_i=1 for 3 cycles at pc_o=0x8000_0010, redirects 0x8000_0080 then 0x8000_0090 during the stall; release.
  -> pc_o held at 0x8000_0010 and adv_cnt_o unchanged during the stall.
  -> after release pc_o=0x8000_0090 (latest wins); then 0x8000_0094.
  -> repeat with a fresh redirect 0x8000_00A0 in the release cycle -> pc_o=0x8000_00A0.
- Misaligned target: redirect to 0x8000_0042.
  -> pc_o=0x8000_0100, misalign_o=1 for one cycle, badaddr_o=0x8000_0042; then pc_o=0x8000_0104 with misalign_o=0.
- Halt: halt_i=1 together with stall_i=1 and redirect 0x8000_0200 at pc_o=0x8000_0020.
  -> halted_o=1 next cycle, pc_valid_o=0, pc_o frozen at 0x8000_0020 for 10 cycles despite redirect/stall activity.
  -> rst restores the reset values.
- Wrap: set RESET_PC=32'hFFFF_FFF8.
  -> pc_o sequence FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
